// File: rtl/morph_ctrl.sv
// Controller for the 5x5 binary morphology datapath: line-period lock, frame-aligned mode select, output mux.
// Optional frame counter enabled by defining MORPH_CTRL_FRAME_CNT_EN.
module morph_ctrl #(
  parameter int HS_W     = 12,
  parameter int TAPS     = 5,
  parameter int MIN_LINE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            h_sync_in,
  input  logic [1:0]      cfg_mode,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [23:0]     pixel_mediana,
  input  logic [23:0]     pixel_dylatacja,
  input  logic [23:0]     pixel_erozja,
  input  logic            de_f,
  input  logic            h_sync_f,
  input  logic            v_sync_f,
  output logic [23:0]     pixel_out,
  output logic            de_out,
  output logic            h_sync_out,
  output logic            v_sync_out,
  output logic [HS_W-1:0] h_size,
  output logic            locked,
  output logic [1:0]      active_mode,
  output logic [15:0]     frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_MEAS1, S_MEAS2, S_LOCKED} state_t;

  localparam logic [HS_W-1:0] CNT_MAX = '1;
  localparam logic [HS_W-1:0] MIN_P   = HS_W'(MIN_LINE);
  localparam logic [HS_W-1:0] TAPS_P  = HS_W'(TAPS);

  state_t          state, state_nxt;
  logic            h_r, h_d, hs_rise;
  logic            vs_d, vs_rise;
  logic [HS_W-1:0] per_cnt, p1, p1_nxt, h_size_nxt;
  logic            locked_nxt, period_ok;
  logic            pending;
  logic [1:0]      pending_mode;

  assign hs_rise   = h_r & ~h_d;
  assign vs_rise   = v_sync_f & ~vs_d;
  assign period_ok = (per_cnt >= MIN_P) && (per_cnt != CNT_MAX);
  assign cfg_ready = ~pending;

  // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_r     <= 1'b0;
      h_d     <= 1'b0;
      vs_d    <= 1'b0;
      per_cnt <= '0;
    end else begin
      h_r  <= h_sync_in;
      h_d  <= h_r;
      vs_d <= v_sync_f;
      if (hs_rise)
        per_cnt <= HS_W'(1);
      else if (per_cnt != CNT_MAX)
        per_cnt <= per_cnt + HS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      p1     <= '0;
      h_size <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      p1     <= p1_nxt;
      h_size <= h_size_nxt;
      locked <= locked_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    p1_nxt     = p1;
    h_size_nxt = h_size;
    locked_nxt = locked;
    if (hs_rise) begin
      case (state)
        S_IDLE: state_nxt = S_MEAS1;
        S_MEAS1: begin
          if (period_ok) begin
            p1_nxt    = per_cnt;
            state_nxt = S_MEAS2;
          end
        end
        S_MEAS2: begin
          if (period_ok && per_cnt == p1) begin
            h_size_nxt = per_cnt - TAPS_P;
            locked_nxt = 1'b1;
            state_nxt  = S_LOCKED;
          end else begin
            p1_nxt = per_cnt;
          end
        end
        S_LOCKED: begin
          if (!period_ok || per_cnt != p1) begin
            locked_nxt = 1'b0;
            p1_nxt     = per_cnt;
            state_nxt  = S_MEAS2;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // A request accepted in the same cycle as a v_sync edge sees pending=0 there, so it waits one frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= 1'b0;
      pending_mode <= 2'd0;
      active_mode  <= 2'd0;
    end else if (vs_rise && pending) begin
      active_mode <= pending_mode;
      pending     <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      pending_mode <= cfg_mode;
      pending      <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out  <= '0;
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
    end else begin
      de_out     <= de_f;
      h_sync_out <= h_sync_f;
      v_sync_out <= v_sync_f;
      if (!locked || !de_f)
        pixel_out <= '0;
      else begin
        case (active_mode)
          2'd0:    pixel_out <= pixel_mediana;
          2'd1:    pixel_out <= pixel_dylatacja;
          2'd2:    pixel_out <= pixel_erozja;
          default: pixel_out <= '0;
        endcase
      end
    end
  end

`ifdef MORPH_CTRL_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= '0;
    else if (vs_rise)
      frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule
